// File: rtl/instr_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and the memory side (slave).
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 16
) ();
  logic [PC_WIDTH-1:0] pc;
  logic                imem_req;
  logic                imem_ack;
  logic [23:0]         imem_rdata;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;

  modport master (
    output pc, imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  pc, imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC and IR, handshakes with memories and
// issues one-cycle write strobes around the combinational control unit.
module instr_sequencer #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cmp_true,
  input  logic [PC_WIDTH-1:0] branch_target,
  instr_sequencer_if.master   mem,
  output logic [23:0]         ir,
  output logic                reg_we,
  output logic                flags_we,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [23:0]         ir_q, ir_d;
  logic [15:0]         retired_q, retired_d;

  logic [1:0] cls;
  logic       is_load, is_store, is_halt, retire;

  // Class decode works on the registered IR only, so no output depends on an ack.
  always_comb begin
    cls      = ir_q[23:22];
    is_load  = (cls == 2'b01) && (ir_q[13:12] == 2'b00);
    is_store = (cls == 2'b01) && (ir_q[13:12] == 2'b01);
    is_halt  = (cls == 2'b11) && (ir_q[14:12] == 3'b100);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack) begin
          ir_d    = mem.imem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (cls)
          2'b00: state_d = S_WB;
          2'b01: begin
            if (is_load || is_store) begin
              state_d = S_MEM;
            end else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
          2'b10: begin
            if (ir_q[0] || cmp_true) pc_d = branch_target;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d = is_halt ? S_HALT : S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    retired_d = retire ? (retired_q + 16'd1) : retired_q;
  end

  // Requests and strobes each map to a distinct state, which keeps them mutually exclusive.
  always_comb begin
    mem.imem_req = (state_q == S_FETCH);
    mem.dmem_req = (state_q == S_MEM);
    mem.dmem_we  = (state_q == S_MEM) && is_store;
    flags_we     = (state_q == S_EXEC) && (cls == 2'b00);
    reg_we       = (state_q == S_WB);
    halted       = (state_q == S_HALT);
  end

  assign mem.pc  = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;

endmodule
